// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory watchdog and retire counter
module multicycle_sequencer #(
  parameter int WATCHDOG_CYCLES = 15,
  parameter int RETIRE_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [3:0]              opcode,
  input  logic                    zero,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_req,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    reg_dest,
  output logic                    alu_src,
  output logic [1:0]              alu_op,
  output logic                    mem_to_reg,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    reg_write,
  output logic                    branch_taken,
  output logic                    illegal_op,
  output logic                    mem_fault,
  output logic                    halted,
  output logic [2:0]              state,
  output logic [RETIRE_CNT_W-1:0] retired_count
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t                  state_q, state_d;
  logic [7:0]              wd_q, wd_d;
  logic [RETIRE_CNT_W-1:0] ret_q;
  logic                    oor_q;
  logic                    is_r, is_i, is_lw, is_sw, is_beq, legal;
  logic                    waiting, rdy, fault, retire, taken;
  always_comb begin
    is_r       = opcode[3:2] == 2'b00 && opcode[1:0] != 2'b11;
    is_i       = opcode[3:2] == 2'b10 && opcode[1:0] != 2'b00;
    is_lw      = opcode == 4'b1100;
    is_sw      = opcode == 4'b1101;
    is_beq     = opcode == 4'b1111;
    legal      = is_r | is_i | is_lw | is_sw | is_beq;
    imem_req   = state_q == FETCH && run && oor_q;
    waiting    = imem_req || state_q == MEM;
    rdy        = state_q == MEM ? dmem_ready : imem_ready;
    // the limit cycle still honours a same-cycle ready; only a miss there aborts
    fault      = waiting && !rdy && wd_q == 8'(WATCHDOG_CYCLES - 1);
    wd_d       = (waiting && !rdy && !fault) ? wd_q + 8'd1 : 8'd0;
    taken      = is_beq && zero;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dest   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    branch_taken = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    state_d    = state_q;
    case (state_q)
      FETCH: begin
        ir_write = imem_req && imem_ready;
        pc_write = imem_req && imem_ready;
        state_d  = (imem_req && imem_ready) ? DECODE : FETCH;
      end
      DECODE: begin
        illegal_op = !legal;
        state_d    = legal ? EXEC : FETCH;
      end
      EXEC: begin
        alu_src      = is_i | is_lw | is_sw;
        alu_op       = is_r ? 2'b10 : is_i ? 2'b11 : is_beq ? 2'b01 : 2'b00;
        pc_write     = taken;
        pc_src       = taken;
        branch_taken = taken;
        retire       = is_beq;
        state_d      = (is_lw | is_sw) ? MEM : (is_r | is_i) ? WB : FETCH;
      end
      MEM: begin
        alu_src   = 1'b1;
        mem_read  = is_lw && !fault;
        mem_write = !is_lw && !fault;
        retire    = dmem_ready && !is_lw;
        state_d   = dmem_ready ? (is_lw ? WB : FETCH) : fault ? FETCH : MEM;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dest   = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    mem_fault     = fault;
    halted        = state_q == FETCH && !run;
    state         = state_q;
    retired_count = ret_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wd_q    <= 8'd0;
      ret_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      ret_q   <= retire ? ret_q + RETIRE_CNT_W'(1) : ret_q;
      oor_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed scenario tests for the multi-cycle control sequencer
module tb_multicycle_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b1, zero = 1'b0;
  logic [3:0] opcode = 4'b0001;
  logic       imem_ready = 1'b1, dmem_ready = 1'b1;
  logic       imem_req, ir_write, pc_write, pc_src, reg_dest, alu_src, mem_to_reg;
  logic       mem_read, mem_write, reg_write, branch_taken, illegal_op, mem_fault, halted;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [3:0] retired_count;
  logic [3:0] exp_ret = 4'd0;
  int total = 0, bad = 0;

  multicycle_sequencer #(.WATCHDOG_CYCLES(15), .RETIRE_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_dest(reg_dest),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .branch_taken(branch_taken),
    .illegal_op(illegal_op), .mem_fault(mem_fault), .halted(halted), .state(state),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // fetch one instruction from FETCH (run low), leave the FSM in DECODE with run/imem_ready low
  task automatic start(input logic [3:0] op);
    opcode = op;
    run = 1'b1;
    imem_ready = 1'b1;
    #1;
    tick();
    run = 1'b0;
    imem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    total++;
    #3;
    if ({state, imem_req, halted, reg_write, pc_write, ir_write} !== 8'b0 || retired_count !== 4'd0) begin
      bad++; $display("FAIL reset_outputs got st=%0d req=%b hlt=%b rw=%b cnt=%0d exp all zero", state, imem_req, halted, reg_write, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL req_before_first_edge got=%b exp=0", imem_req); end
    tick(); #1;
    total++;
    if ({state, imem_req, ir_write, pc_write, pc_src} !== 7'b000_1110) begin
      bad++; $display("FAIL first_fetch got st=%0d req=%b ir=%b pcw=%b src=%b exp st=0 1 1 1 0", state, imem_req, ir_write, pc_write, pc_src);
    end
    tick(); #1;
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL r_decode got=%0d exp=1", state); end
    tick(); #1;
    total++;
    if ({state, alu_op, alu_src} !== 6'b010_10_0) begin bad++; $display("FAIL r_exec got st=%0d op=%b src=%b exp 2 10 0", state, alu_op, alu_src); end
    run = 1'b0;
    tick(); #1;
    total++;
    if ({state, reg_write, reg_dest, mem_to_reg} !== 6'b100_110) begin
      bad++; $display("FAIL r_wb got st=%0d rw=%b rd=%b m2r=%b exp 4 1 1 0", state, reg_write, reg_dest, mem_to_reg);
    end
    tick(); #1;
    exp_ret++;
    total++;
    if ({state, halted, imem_req} !== 5'b000_10 || retired_count !== exp_ret) begin
      bad++; $display("FAIL r_retire got st=%0d hlt=%b req=%b cnt=%0d exp 0 1 0 cnt=%0d", state, halted, imem_req, retired_count, exp_ret);
    end
  endtask

  task automatic test_lw();
    start(4'b1100);
    tick(); #1;
    total++;
    if ({state, alu_src, alu_op} !== 6'b010_1_00) begin bad++; $display("FAIL lw_exec got st=%0d src=%b op=%b exp 2 1 00", state, alu_src, alu_op); end
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dmem_ready = 1'b1;
      #1;
      total++;
      if ({state, mem_read, mem_write, alu_src} !== 6'b011_101) begin
        bad++; $display("FAIL lw_mem_wait%0d got st=%0d rd=%b wr=%b src=%b exp 3 1 0 1", i, state, mem_read, mem_write, alu_src);
      end
    end
    tick();
    dmem_ready = 1'b0;
    #1;
    total++;
    if ({state, reg_write, reg_dest, mem_to_reg} !== 6'b100_101) begin
      bad++; $display("FAIL lw_wb got st=%0d rw=%b rd=%b m2r=%b exp 4 1 0 1", state, reg_write, reg_dest, mem_to_reg);
    end
    tick(); #1;
    exp_ret++;
    total++;
    if (state !== 3'd0 || retired_count !== exp_ret) begin bad++; $display("FAIL lw_retire got st=%0d cnt=%0d exp 0 %0d", state, retired_count, exp_ret); end
  endtask

  task automatic test_sw();
    start(4'b1101);
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) dmem_ready = 1'b1;
      #1;
      total++;
      if ({state, mem_write, mem_read, reg_write, pc_write} !== 7'b011_1000) begin
        bad++; $display("FAIL sw_mem%0d got st=%0d wr=%b rd=%b rw=%b pcw=%b exp 3 1 0 0 0", i, state, mem_write, mem_read, reg_write, pc_write);
      end
    end
    tick();
    dmem_ready = 1'b0;
    #1;
    exp_ret++;
    total++;
    if ({state, reg_write} !== 4'b000_0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL sw_retire got st=%0d rw=%b cnt=%0d exp 0 0 %0d", state, reg_write, retired_count, exp_ret);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      start(4'b1111);
      tick(); #1;
      total++;
      if ({state, alu_op, alu_src, pc_write, pc_src, branch_taken} !== {3'd2, 2'b01, 1'b0, {3{z[0]}}}) begin
        bad++; $display("FAIL beq_exec_z%0d got st=%0d op=%b src=%b pcw=%b psrc=%b bt=%b", z, state, alu_op, alu_src, pc_write, pc_src, branch_taken);
      end
      tick(); #1;
      exp_ret++;
      total++;
      if ({state, branch_taken} !== 4'b0 || retired_count !== exp_ret) begin
        bad++; $display("FAIL beq_retire_z%0d got st=%0d bt=%b cnt=%0d exp 0 0 %0d", z, state, branch_taken, retired_count, exp_ret);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    start(4'b0100);
    total++;
    if ({state, illegal_op} !== 4'b001_1) begin bad++; $display("FAIL illegal_decode got st=%0d ill=%b exp 1 1", state, illegal_op); end
    tick(); #1;
    total++;
    if ({state, illegal_op} !== 4'b0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL illegal_return got st=%0d ill=%b cnt=%0d exp 0 0 %0d", state, illegal_op, retired_count, exp_ret);
    end
  endtask

  task automatic test_watchdog();
    start(4'b1100);
    tick();
    dmem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick(); #1;
      total++;
      if ({state, mem_fault, reg_write} !== {3'd3, i == 15, 1'b0}) begin
        bad++; $display("FAIL wd_stuck_cycle%0d got st=%0d flt=%b rw=%b exp 3 %0d 0", i, state, mem_fault, reg_write, i == 15);
      end
    end
    tick(); #1;
    total++;
    if ({state, mem_fault, reg_write} !== 5'b0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL wd_abort got st=%0d flt=%b rw=%b cnt=%0d exp 0 0 0 %0d", state, mem_fault, reg_write, retired_count, exp_ret);
    end
    start(4'b1100);
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) dmem_ready = 1'b1;
      #1;
      total++;
      if ({state, mem_fault, mem_read} !== 5'b011_01) begin
        bad++; $display("FAIL wd_late_ready_cycle%0d got st=%0d flt=%b rd=%b exp 3 0 1", i, state, mem_fault, mem_read);
      end
    end
    tick();
    dmem_ready = 1'b0;
    #1;
    total++;
    if ({state, reg_write, mem_to_reg} !== 5'b100_11) begin bad++; $display("FAIL wd_late_wb got st=%0d rw=%b m2r=%b exp 4 1 1", state, reg_write, mem_to_reg); end
    tick(); #1;
    exp_ret++;
    total++;
    if (retired_count !== exp_ret) begin bad++; $display("FAIL wd_late_retire got=%0d exp=%0d", retired_count, exp_ret); end
  endtask

  task automatic test_run_drop();
    start(4'b1100);
    dmem_ready = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({state, mem_read} !== 4'b011_1) begin bad++; $display("FAIL drop_mem got st=%0d rd=%b exp 3 1", state, mem_read); end
    tick(); tick(); #1;
    exp_ret++;
    total++;
    if ({state, halted, imem_req} !== 5'b000_10 || retired_count !== exp_ret) begin
      bad++; $display("FAIL drop_halt got st=%0d hlt=%b req=%b cnt=%0d exp 0 1 0 %0d", state, halted, imem_req, retired_count, exp_ret);
    end
  endtask

  task automatic test_async_reset();
    start(4'b1101);
    dmem_ready = 1'b0;
    tick(); tick(); #1;
    total++;
    if ({state, mem_write} !== 4'b011_1) begin bad++; $display("FAIL arst_pre got st=%0d wr=%b exp 3 1", state, mem_write); end
    #1 rst_n = 1'b0;
    #1;
    exp_ret = 4'd0;
    total++;
    if ({state, mem_write, reg_write, pc_write, ir_write, mem_read} !== 8'b0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL arst_immediate got st=%0d wr=%b rw=%b pcw=%b cnt=%0d exp all zero", state, mem_write, reg_write, pc_write, retired_count);
    end
    rst_n = 1'b1;
    tick(); #1;
  endtask

  task automatic test_wrap();
    zero = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      start(4'b1111);
      tick(); tick(); #1;
      exp_ret++;
      if (n >= 15) begin
        total++;
        if (retired_count !== exp_ret) begin bad++; $display("FAIL wrap_after_%0d got=%0d exp=%0d", n, retired_count, exp_ret); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_watchdog();
    test_run_drop();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the processor datapath for the 4-bit-opcode ISA over FETCH/DECODE/EXEC/MEM/WB states, replacing per-instruction single-cycle control.
- Handshakes with instruction and data memories, which may have variable latency, and aborts stalled accesses with a watchdog.
- Drives PC/IR write enables, datapath mux selects and the ALUOp code for the ALU control decoder.
- Counts retired instructions.

Parameters:
- WATCHDOG_CYCLES, 15: maximum consecutive cycles a memory request may wait for ready before abort (1..255).
- RETIRE_CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetch new instructions; sampled only in FETCH.
- opcode  in  4  IR[15:12]; stable from DECODE onward because IR is written only at end of FETCH.
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  0 = PC+2, 1 = branch target.
- reg_dest  out  1  1 = rd, 0 = rt.
- alu_src  out  1  1 = immediate.
- alu_op  out  2  00 add (LW/SW), 01 sub (BEQ), 10 R-type funct, 11 I-type.
- mem_to_reg  out  1  1 = write-back data from memory.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- reg_write  out  1  register file write enable.
- branch_taken  out  1  one-cycle pulse.
- illegal_op  out  1  one-cycle pulse.
- mem_fault  out  1  one-cycle pulse on watchdog abort.
- halted  out  1  1 when in FETCH with run=0.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- retired_count  out  RETIRE_CNT_W  instructions completed; wraps to 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH; retired_count=0; watchdog counter=0; out_of_reset flag=0.
  - All outputs 0, except halted = ~run and state=0.
  - out_of_reset sets on the first clk edge after release, so the first imem_req occurs one cycle after reset deassertion.
- Outputs are combinational from state, opcode and handshake inputs. Only state, watchdog counter, retired_count and out_of_reset are registered.
- Legal opcodes:
  - 0000, 0001, 0010: R-type.
  - 1001 ADDI, 1010 SUBI, 1011 SLTI.
  - 1100 LW, 1101 SW, 1111 BEQ.
  - All other opcodes are illegal.
- FETCH:
  - imem_req = run & out_of_reset.
  - When imem_req & imem_ready: ir_write=1, pc_write=1, pc_src=0 in that same cycle; go to DECODE.
  - When run=0: hold in FETCH with halted=1. An instruction already in flight always completes first.
- DECODE (one cycle):
  - Illegal opcode: illegal_op=1, go to FETCH, no retire.
  - Legal opcode: go to EXEC.
- EXEC (one cycle):
  - R-type: alu_src=0, alu_op=10. I-type: alu_src=1, alu_op=11. Both go to WB.
  - LW/SW: alu_src=1, alu_op=00; go to MEM.
  - BEQ: alu_src=0, alu_op=01. If zero=1, also pc_write=1, pc_src=1, branch_taken=1. Go to FETCH and retire.
- MEM:
  - LW: mem_read=1, alu_op=00, alu_src=1 held until dmem_ready; then go to WB.
  - SW: mem_write=1 held until dmem_ready; then go to FETCH and retire.
  - A zero-wait memory (ready in the first MEM cycle) spends exactly one cycle in MEM.
- WB (one cycle):
  - reg_write=1.
  - reg_dest=1 for R-type, 0 otherwise.
  - mem_to_reg=1 for LW only.
  - Go to FETCH and retire.
- Retire: retired_count increments by 1 on the exit edge, modulo 2^RETIRE_CNT_W.
- Instruction latencies (zero-wait memory): R/I = 4 cycles, LW = 5, SW = 4, BEQ = 3.
- Watchdog:
  - Counts consecutive cycles in FETCH (with imem_req=1) or MEM where ready=0.
  - Clears on ready=1 and on any state change.
  - When the count reaches WATCHDOG_CYCLES and ready is still 0: mem_fault=1 for one cycle, go to FETCH, no ir/pc/reg/mem writes, no retire.
  - A ready arriving in the same cycle as the limit wins; the access completes normally.
- Ready inputs are ignored in states that are not waiting on them.
- reg_write, mem_write and pc_write are never asserted together in one cycle.

Test Plan:
- Reset release with run=1, opcode=0001, both memories zero-wait: imem_req first asserts cycle 1 after release; state sequence 0,1,2,4,0; reg_write and reg_dest=1 in WB; retired_count=1 after 4 cycles.
- LW (1100) with dmem_ready delayed 3 cycles: mem_read high for 4 MEM cycles, then WB with mem_to_reg=1, reg_dest=0; SW (1101): mem_write held until ready, reg_write never 1.
- BEQ with zero=1: EXEC shows pc_write=1, pc_src=1, branch_taken=1, next state FETCH; with zero=0, pc_write=0; both retire.
- Opcode 0100: DECODE raises illegal_op for exactly one cycle, returns to FETCH, retired_count unchanged.
- MEM with dmem_ready stuck 0, WATCHDOG_CYCLES=15: mem_fault pulses on the 15th wait cycle, state goes to 0, no reg_write; repeat with ready arriving on the 15th cycle: normal completion, no fault.
- run dropped mid-LW: instruction completes and retires, then halted=1 and imem_req=0. Async rst_n pulse mid-MEM: state goes to 0 and all write enables drop immediately, without waiting for clk. RETIRE_CNT_W=4: after 16 retires, count wraps to 0.
